// File: rtl/rc4_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rc4_pkg: state encoding, mode selects and plaintext charset          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rc4_pkg;

  typedef enum logic [7:0] {
    ST_IDLE      = 8'd0,
    ST_INIT      = 8'd1,
    ST_GAP_A     = 8'd2,
    ST_SHUF      = 8'd3,
    ST_GAP_B     = 8'd4,
    ST_DEC       = 8'd5,
    ST_CHECK     = 8'd6,
    ST_DONE_OK   = 8'd7,
    ST_DONE_FAIL = 8'd8
  } state_e;

  localparam logic [2:0] MODE_IDLE = 3'b000;
  localparam logic [2:0] MODE_INIT = 3'b001;
  localparam logic [2:0] MODE_SHUF = 3'b010;
  localparam logic [2:0] MODE_DEC  = 3'b100;

  localparam logic [7:0] CHAR_LO_DEFAULT    = 8'h61;
  localparam logic [7:0] CHAR_HI_DEFAULT    = 8'h7A;
  localparam logic [7:0] CHAR_SPACE_DEFAULT = 8'h20;

  function automatic logic [2:0] mode_of(input state_e s);
    case (s)
      ST_INIT: mode_of = MODE_INIT;
      ST_SHUF: mode_of = MODE_SHUF;
      ST_DEC:  mode_of = MODE_DEC;
      default: mode_of = MODE_IDLE;
    endcase
  endfunction

  function automatic logic is_busy(input state_e s);
    return s inside {ST_INIT, ST_GAP_A, ST_SHUF, ST_GAP_B, ST_DEC, ST_CHECK};
  endfunction

endpackage
`default_nettype wire

// File: rtl/plaintext_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | plaintext_checker: sticky flag for any illegal byte written to A-RAM |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module plaintext_checker
  import rc4_pkg::*;
#(
  parameter int                   RAM_WIDTH  = 8,
  parameter logic [RAM_WIDTH-1:0] CHAR_LO    = RAM_WIDTH'(CHAR_LO_DEFAULT),
  parameter logic [RAM_WIDTH-1:0] CHAR_HI    = RAM_WIDTH'(CHAR_HI_DEFAULT),
  parameter logic [RAM_WIDTH-1:0] CHAR_SPACE = RAM_WIDTH'(CHAR_SPACE_DEFAULT)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 enable_i,
  input  logic                 wren_i,
  input  logic [RAM_WIDTH-1:0] data_i,
  output logic                 bad_o
);

  logic w_legal;
  logic bad_q;

  assign w_legal = ((data_i >= CHAR_LO) && (data_i <= CHAR_HI)) || (data_i == CHAR_SPACE);

  // Clear wins so a fresh candidate never inherits a verdict from the previous key.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bad_q <= 1'b0;
    end else if (clear_i) begin
      bad_q <= 1'b0;
    end else if (enable_i && wren_i && !w_legal) begin
      bad_q <= 1'b1;
    end
  end

  assign bad_o = bad_q;

endmodule
`default_nettype wire

// File: rtl/rc4_key_search_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rc4_key_search_sequencer: init/shuffle/decrypt phasing per key       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rc4_key_search_sequencer
  import rc4_pkg::*;
#(
  parameter int                   RAM_WIDTH       = 8,
  parameter int                   KEY_LENGTH      = 3,
  parameter int                   KEY_SEARCH_BITS = 22,
  parameter int                   NUM_DEVICES     = 3,
  parameter logic [RAM_WIDTH-1:0] CHAR_LO         = RAM_WIDTH'(CHAR_LO_DEFAULT),
  parameter logic [RAM_WIDTH-1:0] CHAR_HI         = RAM_WIDTH'(CHAR_HI_DEFAULT),
  parameter logic [RAM_WIDTH-1:0] CHAR_SPACE      = RAM_WIDTH'(CHAR_SPACE_DEFAULT)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [NUM_DEVICES-1:0]           finish_bus,
  input  logic                             aWren,
  input  logic [RAM_WIDTH-1:0]             aIn,
  output logic [2:0]                       mode,
  output logic [KEY_LENGTH*RAM_WIDTH-1:0]  key,
  output logic                             busy,
  output logic                             found,
  output logic                             fail,
  output logic [7:0]                       stateTap
);

  localparam int KEY_W = KEY_LENGTH * RAM_WIDTH;

  state_e                     state_q, state_d;
  logic [KEY_W-1:0]           key_q, key_d;
  logic [KEY_SEARCH_BITS-1:0] w_low_inc;
  logic [2:0]                 mode_q;
  logic                       busy_q, found_q, fail_q;
  logic                       w_clear_bad;
  logic                       w_bad;

  assign w_low_inc = key_q[KEY_SEARCH_BITS-1:0] + KEY_SEARCH_BITS'(1);

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    w_clear_bad = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE_OK, ST_DONE_FAIL: begin
        if (start) begin
          state_d     = ST_INIT;
          key_d       = '0;
          w_clear_bad = 1'b1;
        end
      end
      ST_INIT:  if (finish_bus[0]) state_d = ST_GAP_A;
      ST_GAP_A: state_d = ST_SHUF;
      ST_SHUF:  if (finish_bus[1]) state_d = ST_GAP_B;
      ST_GAP_B: begin
        state_d     = ST_DEC;
        w_clear_bad = 1'b1;
      end
      ST_DEC:   if (finish_bus[2]) state_d = ST_CHECK;
      ST_CHECK: begin
        if (!w_bad) begin
          state_d = ST_DONE_OK;
        end else if (&key_q[KEY_SEARCH_BITS-1:0]) begin
          // The all-ones candidate is the last one; never wrap back to zero.
          state_d = ST_DONE_FAIL;
        end else begin
          state_d = ST_INIT;
          key_d   = KEY_W'(w_low_inc);
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land on the same edge as the transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      mode_q  <= MODE_IDLE;
      busy_q  <= 1'b0;
      found_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      mode_q  <= mode_of(state_d);
      busy_q  <= is_busy(state_d);
      found_q <= (state_d == ST_DONE_OK);
      fail_q  <= (state_d == ST_DONE_FAIL);
    end
  end

  plaintext_checker #(
    .RAM_WIDTH  (RAM_WIDTH),
    .CHAR_LO    (CHAR_LO),
    .CHAR_HI    (CHAR_HI),
    .CHAR_SPACE (CHAR_SPACE)
  ) u_checker (
    .clk_i    (clk),
    .rst_i    (reset),
    .clear_i  (w_clear_bad),
    .enable_i (state_q == ST_DEC),
    .wren_i   (aWren),
    .data_i   (aIn),
    .bad_o    (w_bad)
  );

  assign mode     = mode_q;
  assign key      = key_q;
  assign busy     = busy_q;
  assign found    = found_q;
  assign fail     = fail_q;
  assign stateTap = state_q;

endmodule
`default_nettype wire

// File: tb/tb_rc4_key_search_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rc4_key_search_sequencer: random RAM-controller stand-in + model  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rc4_key_search_sequencer;

  localparam int RW  = 8;
  localparam int KL  = 3;
  localparam int KSB = 2;
  localparam int ND  = 3;
  localparam int KW  = KL * RW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [ND-1:0] finish_bus = '0;
  logic          aWren = 1'b0;
  logic [RW-1:0] aIn = '0;
  logic [2:0]    mode;
  logic [KW-1:0] key;
  logic          busy, found, fail;
  logic [7:0]    stateTap;

  rc4_key_search_sequencer #(
    .RAM_WIDTH       (RW),
    .KEY_LENGTH      (KL),
    .KEY_SEARCH_BITS (KSB),
    .NUM_DEVICES     (ND),
    .CHAR_LO         (8'h61),
    .CHAR_HI         (8'h7A),
    .CHAR_SPACE      (8'h20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .finish_bus (finish_bus),
    .aWren      (aWren),
    .aIn        (aIn),
    .mode       (mode),
    .key        (key),
    .busy       (busy),
    .found      (found),
    .fail       (fail),
    .stateTap   (stateTap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // phase numbers follow the debug tap: 0 idle,1 init,2 gap,3 shuf,4 gap,5 dec,6 check,7 ok,8 fail
  int m_phase = 0;
  int m_key   = 0;
  bit m_bad   = 1'b0;

  function automatic bit legal(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  function automatic logic [2:0] m_mode(input int p);
    if (p == 1 || p == 3 || p == 5) return 3'(1 << ((p - 1) / 2));
    return 3'b000;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0;
      m_key   = 0;
      m_bad   = 1'b0;
    end else begin : step
      bit nb;
      nb = m_bad;
      if (m_phase == 5 && aWren && !legal(aIn)) nb = 1'b1;
      if (m_phase == 4) nb = 1'b0;
      if (m_phase == 0 || m_phase >= 7) begin
        if (start) begin
          m_phase = 1;
          m_key   = 0;
          nb      = 1'b0;
        end
      end else if (m_phase == 2 || m_phase == 4) begin
        m_phase = m_phase + 1;
      end else if (m_phase == 6) begin
        if (!m_bad) m_phase = 7;
        else if (m_key == (1 << KSB) - 1) m_phase = 8;
        else begin
          m_key   = m_key + 1;
          m_phase = 1;
        end
      end else if (finish_bus[(m_phase - 1) / 2]) begin
        m_phase = m_phase + 1;
      end
      m_bad = nb;
    end
    #1;
    if (!reset)
      check("outputs", {mode, key, busy, found, fail, stateTap},
            {m_mode(m_phase), KW'(m_key), (m_phase >= 1 && m_phase <= 6),
             (m_phase == 7), (m_phase == 8), 8'(m_phase)});
  end

  // ---------------- RAM-controller stand-in ----------------
  int         lat [3];
  int         style_by_key [4];
  bit         hold_all = 1'b0;
  bit         noise    = 1'b0;
  bit         rec_en   = 1'b0;
  logic [2:0] rec_q [$];
  logic [2:0] prev_mode = 3'b000;
  int         cnt = 0;
  logic [7:0] hi_b [3] = '{8'h68, 8'h69, 8'h20};

  function automatic logic [7:0] legal_byte();
    case ($urandom % 4)
      0:       return 8'h61;
      1:       return 8'h7A;
      2:       return 8'h20;
      default: return 8'h61 + 8'($urandom % 26);
    endcase
  endfunction

  function automatic logic [7:0] bad_byte();
    case ($urandom % 7)
      0:       return 8'h60;
      1:       return 8'h7B;
      2:       return 8'h1F;
      3:       return 8'h21;
      4:       return 8'h41;
      5:       return 8'h00;
      default: return 8'hFF;
    endcase
  endfunction

  always @(negedge clk) begin : drive
    int         st;
    logic [2:0] fb;
    if (mode !== prev_mode) begin
      cnt = 0;
      if (rec_en) rec_q.push_back(mode);
    end else begin
      cnt = cnt + 1;
    end
    prev_mode = mode;
    fb    = 3'b000;
    aWren = 1'b0;
    aIn   = 8'($urandom);
    if (hold_all) begin
      fb = 3'b111;
    end else begin
      for (int i = 0; i < 3; i++) if (mode[i] === 1'b1 && cnt >= lat[i]) fb[i] = 1'b1;
      if (noise) fb = fb | (3'($urandom) & ~mode);
    end
    if (mode === 3'b100) begin
      st = style_by_key[key[1:0]];
      case (st)
        0: if (cnt < 3) begin aWren = 1'b1; aIn = hi_b[cnt]; end
        1: begin aWren = 1'($urandom % 2); aIn = legal_byte(); end
        2: begin
          aWren = (cnt == 0) || ($urandom % 2 == 1);
          aIn   = (cnt == 0) ? 8'h41 : legal_byte();
        end
        3: begin aWren = 1'($urandom % 2); aIn = ($urandom % 2 == 1) ? legal_byte() : bad_byte(); end
        default: begin aWren = 1'b1; aIn = fb[2] ? 8'h7B : legal_byte(); end
      endcase
    end else if (noise && ($urandom % 2 == 1)) begin
      aWren = 1'b1;
      aIn   = bad_byte();
    end
    finish_bus = fb;
  end

  // ---------------- scenario helpers ----------------
  task automatic cfg(input int l0, input int l1, input int l2,
                     input int s0, input int s1, input int s2, input int s3,
                     input bit nz, input bit ha);
    lat[0] = l0; lat[1] = l1; lat[2] = l2;
    style_by_key[0] = s0; style_by_key[1] = s1;
    style_by_key[2] = s2; style_by_key[3] = s3;
    noise = nz; hold_all = ha;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (!(found === 1'b1 || fail === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {found | fail}, 1);
  endtask

  task automatic wait_mode_key(input logic [2:0] m, input int k, input int budget, input string name);
    int n;
    n = 0;
    while (!(mode === m && key === KW'(k)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {mode, key}, {m, KW'(k)});
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [17:0] seq;
    cfg(256, 768, 100, 0, 0, 0, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_state", {mode, key, busy, found, fail, stateTap}, 0);

    // Long phases, clean plaintext "hi "
    rec_q.delete();
    rec_en = 1'b1;
    pulse_start();
    check("start_latency", mode, 3'b001);
    wait_done(3000, "t1_done");
    rec_en = 1'b0;
    seq = '0;
    foreach (rec_q[i]) seq = {seq[14:0], rec_q[i]};
    check("t1_mode_seq_len", rec_q.size(), 6);
    check("t1_mode_seq", seq, 18'b001_000_010_000_100_000);
    check("t1_result", {found, fail, busy, key}, {1'b1, 1'b0, 1'b0, 24'h0});

    // First candidate writes 'A', second is clean; restart from DONE_OK clears found at once
    cfg(2, 3, 4, 2, 1, 2, 2, 1'b1, 1'b0);
    pulse_start();
    check("restart_clears", {found, busy, mode, key}, {1'b0, 1'b1, 3'b001, 24'h0});
    wait_done(1000, "t2_done");
    check("t2_result", {found, fail, key}, {1'b1, 1'b0, 24'h1});

    // Every candidate bad (incl. illegal byte alongside finish) -> exhaust 0..3
    cfg(1, 2, 3, 4, 2, 4, 4, 1'b1, 1'b0);
    pulse_start();
    wait_done(2000, "t3_done");
    check("t3_result", {fail, found, key, mode}, {1'b1, 1'b0, 24'h3, 3'b000});

    // All finish flags stuck high, illegal writes outside decrypt
    cfg(0, 0, 0, 1, 1, 1, 1, 1'b1, 1'b1);
    pulse_start();
    wait_done(200, "t4_done");
    check("t4_result", {found, fail, key}, {1'b1, 1'b0, 24'h0});

    // Asynchronous reset in the middle of the second shuffle
    cfg(2, 30, 2, 2, 1, 1, 1, 1'b1, 1'b0);
    pulse_start();
    wait_mode_key(3'b010, 1, 500, "t5_reach_shuf");
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("t5_async_reset", {mode, key, busy, found, fail, stateTap}, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    pulse_start();
    wait_done(1000, "t5_done");
    check("t5_result", {found, key}, {1'b1, 24'h1});

    // start during decrypt is ignored
    cfg(1, 1, 20, 1, 1, 1, 1, 1'b0, 1'b0);
    pulse_start();
    wait_mode_key(3'b100, 0, 200, "t6_reach_dec");
    pulse_start();
    check("t6_start_ignored", {mode, busy, key}, {3'b100, 1'b1, 24'h0});
    wait_done(200, "t6_done");
    check("t6_result", {found, key}, {1'b1, 24'h0});

    // Randomized searches
    for (int r = 0; r < 10; r++) begin
      cfg($urandom % 7, $urandom % 7, $urandom % 7,
          $urandom % 5, $urandom % 5, $urandom % 5, $urandom % 5,
          1'($urandom % 2), ($urandom % 4) == 0);
      pulse_start();
      wait_done(2000, "rand_done");
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
